// File: rtl/fpu_sequencer_pkg.sv
// Shared FPU definitions: opcode and sequencer state encodings, plus the
// per-opcode latency selection used when a command is accepted.
package fpu_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_MUL = 2'b01,
    OP_DIV = 2'b10,
    OP_ILL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int unsigned CNT_W = 6;

  // Counter preload: the op is held for LAT cycles, so the count starts at LAT-1.
  function automatic logic [CNT_W-1:0] lat_preload(
    input op_e         op,
    input int unsigned lat_add,
    input int unsigned lat_mul,
    input int unsigned lat_div
  );
    case (op)
      OP_ADD:  return CNT_W'(lat_add - 1);
      OP_MUL:  return CNT_W'(lat_mul - 1);
      OP_DIV:  return CNT_W'(lat_div - 1);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/fpu_sequencer.sv
// Issues one command at a time to a multi-cycle FPU, holds the operands for the
// op's latency, captures the result and presents it on a valid/ready port.
module fpu_sequencer
  import fpu_sequencer_pkg::*;
#(
  parameter int unsigned LAT_ADD = 16,
  parameter int unsigned LAT_MUL = 16,
  parameter int unsigned LAT_DIV = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic [1:0]  fpu_sel,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  input  logic [31:0] fpu_z,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_err
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  op_e              op_q,    op_d;
  logic [31:0]      a_q,     a_d;
  logic [31:0]      b_q,     b_d;
  logic [31:0]      res_q,   res_d;
  logic             err_q,   err_d;

  always_comb begin
    // NOTE: every next-state signal defaults to its held value first, so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (op_e'(cmd_op) == OP_ILL) begin
            res_d   = '0;
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            op_d    = op_e'(cmd_op);
            a_d     = cmd_a;
            b_d     = cmd_b;
            cnt_d   = lat_preload(op_e'(cmd_op), LAT_ADD, LAT_MUL, LAT_DIV);
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          res_d   = fpu_z;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: every register here, including the operand and result holding registers, has a reset value so nothing from an aborted command survives reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together from pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // cmd_ready is gated by rst so it stays low for the whole reset interval.
  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign fpu_sel   = (state_q == ST_RUN) ? op_q : OP_ILL;
  assign fpu_a     = a_q;
  assign fpu_b     = b_q;
  assign res_valid = (state_q == ST_DONE);
  assign res_data  = res_q;
  assign res_err   = err_q;

endmodule

// File: tb/tb_fpu_sequencer.sv
// Scoreboard bench for fpu_sequencer: the driver pushes the expected response at
// each accepted command, a negedge monitor checks results, latency and issue.
module tb_fpu_sequencer;
  import fpu_sequencer_pkg::*;

  localparam int unsigned LA = 5;
  localparam int unsigned LM = 9;
  localparam int unsigned LD = 30;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [31:0] cmd_a = '0;
  logic [31:0] cmd_b = '0;
  logic [1:0]  fpu_sel;
  logic [31:0] fpu_a, fpu_b, fpu_z;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] res_data;
  logic        res_err;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic [31:0] noise = '0;

  fpu_sequencer #(.LAT_ADD(LA), .LAT_MUL(LM), .LAT_DIV(LD)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .fpu_sel(fpu_sel), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_z(fpu_z),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   = cyc + 1;
    noise = $urandom;
  end

  // FPU stand-in: hand-computed results for the operand pairs used below.
  function automatic logic [31:0] fpu_ref(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b);
    case ({sel, a, b})
      {2'b00, 32'h3F800000, 32'h40000000}: return 32'h40400000; // 1+2
      {2'b00, 32'h3F800000, 32'h3F800000}: return 32'h40000000; // 1+1
      {2'b00, 32'h40000000, 32'h40000000}: return 32'h40800000; // 2+2
      {2'b01, 32'h40000000, 32'h40400000}: return 32'h40C00000; // 2*3
      {2'b10, 32'h3F800000, 32'h40800000}: return 32'h3E800000; // 1/4
      default:                             return 32'hBAD0BAD0;
    endcase
  endfunction

  always_comb begin
    fpu_z = noise;
    if (fpu_sel != 2'b11) fpu_z = fpu_ref(fpu_sel, fpu_a, fpu_b);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor
  logic        busy   = 1'b0;
  logic        prev_v = 1'b0;
  logic [31:0] held   = '0;
  int          acc_cyc = 0;

  always @(negedge clk) begin
    if (rst) begin
      busy   = 1'b0;
      prev_v = 1'b0;
    end else begin
      if (busy) check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      if (busy && !res_valid && sb.size() > 0 && sb[0].op != 2'b11) begin
        check("fpu_sel_run", 32'(fpu_sel), 32'(sb[0].op));
        check("fpu_a_run", fpu_a, sb[0].a);
        check("fpu_b_run", fpu_b, sb[0].b);
      end
      if (res_valid && !prev_v) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_result: got res_valid=1 data=%h expected no result", res_data);
        end else begin
          check("res_data", res_data, sb[0].data);
          check("res_err", 32'(res_err), 32'(sb[0].err));
          check("latency", 32'(cyc - acc_cyc), 32'(sb[0].lat));
        end
        held = res_data;
      end
      if (res_valid && prev_v) check("res_data_hold", res_data, held);
      if (res_valid) check("fpu_sel_done", 32'(fpu_sel), 32'd3);
      if (res_valid && res_ready) begin
        busy = 1'b0;
        if (sb.size() > 0) void'(sb.pop_front());
      end
      if (cmd_valid && cmd_ready) begin
        busy    = 1'b1;
        acc_cyc = cyc;
      end
      prev_v = res_valid;
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] data, input logic err, input int lat);
    exp_t e;
    bit   ok = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        e.op = op; e.a = a; e.b = b; e.data = data; e.err = err; e.lat = lat;
        sb.push_back(e);
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout: got no cmd_ready expected accept within 200 cycles");
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_a = $urandom; cmd_b = $urandom;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready && sb.size() == 0) begin ok = 1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL idle_timeout: got busy expected idle within 200 cycles");
    end
  endtask

  task automatic wait_valid();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (res_valid) begin ok = 1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL valid_timeout: got res_valid=0 expected 1 within 200 cycles");
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_fpu_sel"},   32'(fpu_sel),   32'd3);
    check({tag, "_fpu_a"},     fpu_a,          32'd0);
    check({tag, "_fpu_b"},     fpu_b,          32'd0);
    check({tag, "_res_data"},  res_data,       32'd0);
    check({tag, "_res_err"},   32'(res_err),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and first cycle after release
    repeat (2) @(negedge clk);
    check_reset_state("rst");
    #1 rst = 1'b0;
    #1 check("ready_after_rst", 32'(cmd_ready), 32'd1);

    // Add 1+2
    issue(2'b00, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, LA + 1);
    wait_idle();

    // Mul then div back-to-back
    issue(2'b01, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, LM + 1);
    issue(2'b10, 32'h3F800000, 32'h40800000, 32'h3E800000, 1'b0, LD + 1);
    wait_idle();

    // Illegal opcode
    issue(2'b11, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1);
    wait_idle();

    // Backpressure in DONE
    res_ready = 1'b0;
    issue(2'b00, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, LA + 1);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(res_valid), 32'd1);
      check("bp_data", res_data, 32'h40400000);
    end
    @(posedge clk); #1 res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_valid", 32'(res_valid), 32'd0);
    check("bp_release_ready", 32'(cmd_ready), 32'd1);

    // Reset mid-RUN of a divide, counter at 20
    issue(2'b10, 32'h3F800000, 32'h40800000, 32'h3E800000, 1'b0, LD + 1);
    repeat (LD - 1 - 20) @(posedge clk);
    #2 rst = 1'b1;
    sb.delete();
    #1 check_reset_state("midrun");
    @(negedge clk);
    #1 rst = 1'b0;
    #1 check("ready_after_midrun", 32'(cmd_ready), 32'd1);
    repeat (LD + 5) @(negedge clk);
    check("no_stale_result", 32'(res_valid), 32'd0);
    issue(2'b00, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, LA + 1);
    wait_idle();

    // cmd_* noise during RUN
    issue(2'b00, 32'h40000000, 32'h40000000, 32'h40800000, 1'b0, LA + 1);
    for (int i = 0; i < int'(LA) - 2; i++) begin
      @(posedge clk); #1;
      cmd_valid = 1'($urandom);
      cmd_op    = 2'($urandom);
      cmd_a     = $urandom;
      cmd_b     = $urandom;
    end
    @(posedge clk); #1 cmd_valid = 1'b0;
    wait_idle();

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
